// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the ALU sharing controller.
//   - opcode encodings understood by the ALU
//   - controller FSM state encoding
//   - bit positions inside the {N,Z,V} flag register
//   - saturating signed byte add used by the packed ALU op
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD    = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB    = 4'b0001;
    localparam logic [OP_W-1:0] OP_XOR    = 4'b0010;
    localparam logic [OP_W-1:0] OP_RED    = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLL    = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA    = 4'b0101;
    localparam logic [OP_W-1:0] OP_ROR    = 4'b0110;
    localparam logic [OP_W-1:0] OP_PADDSB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    // Signed 8-bit add clamped to [-128, 127]. The 9-bit sign-extended sum
    // overflowed when its top two bits disagree; bit 8 is the true sign.
    function automatic logic [7:0] sat_add8(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] s;
        s = {x[7], x} + {y[7], y};
        if (s[8] != s[7])
            return s[8] ? 8'h80 : 8'h7F;
        return s[7:0];
    endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// alu_share_ctrl_alu: the shared 16-bit combinational ALU.
//   op : opcode (cpu_pkg OP_*)
//   a  : operand A
//   b  : operand B (shift/rotate amount is b[3:0])
//   y  : result; undefined opcodes pass operand A through
module alu_share_ctrl_alu
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic [3:0]          sh;
    logic [2*DATA_W-1:0] rot;
    logic [5:0]          nib_sum;

    assign sh  = b[3:0];
    // Right-shifting a doubled copy leaves the rotated word in the low half.
    assign rot = {a, a} >> sh;
    assign nib_sum = {2'b00, a[3:0]} + {2'b00, a[7:4]}
                   + {2'b00, a[11:8]} + {2'b00, a[15:12]};

    always_comb begin
        y = a;
        case (op)
            OP_ADD:    y = a + b;
            OP_SUB:    y = a - b;
            OP_XOR:    y = a ^ b;
            OP_RED:    y = DATA_W'(nib_sum);
            OP_SLL:    y = a << sh;
            OP_SRA:    y = $unsigned($signed(a) >>> sh);
            OP_ROR:    y = rot[DATA_W-1:0];
            OP_PADDSB: y = {sat_add8(a[15:8], b[15:8]), sat_add8(a[7:0], b[7:0])};
            default:   y = a;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates the single ALU between the execute stage
// (requester 0) and the address/branch-target unit (requester 1).
// One operation in flight: IDLE accepts, EXEC evaluates, RESP holds the
// result until the issuing requester takes it.
//   clk, rst        : clock, async active-high reset
//   req_valid/ready : per-requester request handshake (ready at most one-hot)
//   req_op*/a*/b*   : per-requester opcode and operands
//   rsp_valid/ready : one-hot result handshake addressed to the issuer
//   rsp_data        : registered result
//   flags           : {N,Z,V}, written by requester-0 operations only
//   busy            : controller not in IDLE
module alu_share_ctrl
    import cpu_pkg::*;
#(
    parameter int W   = 16,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [OPW-1:0] req_op0,
    input  logic [OPW-1:0] req_op1,
    input  logic [W-1:0]   req_a0,
    input  logic [W-1:0]   req_a1,
    input  logic [W-1:0]   req_b0,
    input  logic [W-1:0]   req_b1,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic [2:0]     flags,
    output logic           busy
);

    state_e         state;
    logic [OPW-1:0] op_q;
    logic [W-1:0]   a_q, b_q;
    logic           id_q;
    logic           rr_ptr;

    logic           grant, gnt_id;
    logic [W-1:0]   alu_y;
    logic [W-1:0]   raw_sum, raw_dif;
    logic [2:0]     flags_nxt;

    // Single requester wins outright; on contention rr_ptr picks.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = rr_ptr ? 2'b10 : 2'b01;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign grant  = |(req_valid & req_ready);
    assign gnt_id = req_ready[1];
    assign busy   = (state != IDLE);

    alu_share_ctrl_alu u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    // Overflow uses the wrapped sum/difference so it stays correct even if
    // the ALU result itself were clamped.
    assign raw_sum = a_q + b_q;
    assign raw_dif = a_q - b_q;

    always_comb begin
        flags_nxt = flags;
        if (!id_q) begin
            case (op_q)
                OP_ADD: begin
                    flags_nxt[FLAG_N] = alu_y[W-1];
                    flags_nxt[FLAG_Z] = (alu_y == '0);
                    flags_nxt[FLAG_V] = (a_q[W-1] == b_q[W-1]) && (raw_sum[W-1] != a_q[W-1]);
                end
                OP_SUB: begin
                    flags_nxt[FLAG_N] = alu_y[W-1];
                    flags_nxt[FLAG_Z] = (alu_y == '0);
                    flags_nxt[FLAG_V] = (a_q[W-1] != b_q[W-1]) && (raw_dif[W-1] != a_q[W-1]);
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR:
                    flags_nxt[FLAG_Z] = (alu_y == '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            rr_ptr    <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
            flags     <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        op_q   <= gnt_id ? req_op1 : req_op0;
                        a_q    <= gnt_id ? req_a1  : req_a0;
                        b_q    <= gnt_id ? req_b1  : req_b0;
                        id_q   <= gnt_id;
                        rr_ptr <= ~gnt_id;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_y;
                    flags     <= flags_nxt;
                    rsp_valid <= id_q ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[id_q]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed + randomized bench for alu_share_ctrl.
// Accepted requests push an expected response onto a scoreboard; a
// separate monitor compares it whenever the DUT presents rsp_valid.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0 = '0, req_op1 = '0;
    logic [15:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b11;
    logic [15:0] rsp_data;
    logic [2:0]  flags;
    logic        busy;

    alu_share_ctrl #(.W(16), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] op; logic [15:0] a; logic [15:0] b; } req_t;
    typedef struct { logic id; logic [15:0] data; logic [2:0] fl; } exp_t;

    int checks = 0;
    int errors = 0;

    req_t sq0[$];
    req_t sq1[$];
    exp_t sb[$];

    // Reference state: 0 idle, 1 evaluating, 2 holding a response.
    int         m_state = 0;
    logic       m_rr = 1'b0;
    logic       m_id = 1'b0;
    logic [2:0] m_flags = 3'b000;
    logic [1:0] acc = 2'b00;
    bit         rr_rand = 0;
    bit         drop_en = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", nm, $time);
    endtask

    function automatic int sat8(input int s);
        int r;
        r = s;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r & 255;
    endfunction

    function automatic logic [15:0] ref_res(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int u, v, sh, r;
        u  = int'(a);
        v  = int'(b);
        sh = int'(b[3:0]);
        case (op)
            4'd0: r = u + v;
            4'd1: r = u - v;
            4'd2: r = u ^ v;
            4'd3: r = (u & 15) + ((u >> 4) & 15) + ((u >> 8) & 15) + ((u >> 12) & 15);
            4'd4: r = u << sh;
            4'd5: r = int'($signed(a)) >>> sh;
            4'd6: r = (u >> sh) | (u << (16 - sh));
            4'd7: r = (sat8(int'($signed(a[15:8])) + int'($signed(b[15:8]))) << 8)
                    |  sat8(int'($signed(a[7:0]))  + int'($signed(b[7:0])));
            default: r = u;
        endcase
        return r[15:0];
    endfunction

    function automatic logic [2:0] ref_flags(input logic id, input logic [3:0] op,
                                             input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] res, input logic [2:0] cur);
        logic [2:0] f;
        int s;
        f = cur;
        if (id == 1'b0) begin
            if (op == 4'd0 || op == 4'd1) begin
                s = (op == 4'd0) ? int'($signed(a)) + int'($signed(b))
                                 : int'($signed(a)) - int'($signed(b));
                f = {res[15], res == 16'h0000, (s > 32767 || s < -32768)};
            end else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) begin
                f[1] = (res == 16'h0000);
            end
        end
        return f;
    endfunction

    function automatic logic [1:0] arb(input logic [1:0] v, input logic rr);
        if (v == 2'b11) return rr ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic drive(input int i, input req_t r);
        if (i == 0) begin req_op0 = r.op; req_a0 = r.a; req_b0 = r.b; end
        else        begin req_op1 = r.op; req_a1 = r.a; req_b1 = r.b; end
        req_valid[i] = 1'b1;
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        req_t r;
        r.op = op; r.a = a; r.b = b;
        if (i == 0) sq0.push_back(r); else sq1.push_back(r);
    endtask

    // Runs just after the active edge: retire accepted requests, present the next ones.
    task automatic refill();
        req_t r;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                req_valid[i] = 1'b0;
                acc[i] = 1'b0;
            end else if (req_valid[i] && drop_en && $urandom_range(0, 15) == 0) begin
                req_valid[i] = 1'b0;
            end
            if (!req_valid[i]) begin
                if (i == 0 && sq0.size() > 0) begin r = sq0.pop_front(); drive(0, r); end
                if (i == 1 && sq1.size() > 0) begin r = sq1.pop_front(); drive(1, r); end
            end
        end
        if (rr_rand) rsp_ready = 2'($urandom_range(0, 3));
    endtask

    // Mid-cycle: check handshake outputs against the reference, then advance it.
    task automatic model_cycle();
        logic [1:0]  er, ev;
        logic        w;
        exp_t        e;
        logic [3:0]  op;
        logic [15:0] a, b;
        er = 2'b00;
        ev = 2'b00;
        if (m_state == 0) er = arb(req_valid, m_rr);
        if (m_state == 2) ev = m_id ? 2'b10 : 2'b01;
        chk("req_ready", 16'(req_ready), 16'(er));
        chk("rsp_valid", 16'(rsp_valid), 16'(ev));
        chk("busy", 16'(busy), 16'(m_state != 0));
        case (m_state)
            0: if (er != 2'b00) begin
                   w  = er[1];
                   op = w ? req_op1 : req_op0;
                   a  = w ? req_a1  : req_a0;
                   b  = w ? req_b1  : req_b0;
                   e.id   = w;
                   e.data = ref_res(op, a, b);
                   e.fl   = ref_flags(w, op, a, b, e.data, m_flags);
                   m_flags = e.fl;
                   sb.push_back(e);
                   acc[w]  = 1'b1;
                   m_rr    = ~w;
                   m_id    = w;
                   m_state = 1;
               end
            1: m_state = 2;
            default: if (rsp_ready[m_id]) m_state = 0;
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int n;
        n = 0;
        while ((m_state != 0 || req_valid != 2'b00 || sq0.size() > 0 || sq1.size() > 0) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) fail_timeout(nm);
    endtask

    task automatic wait_accept(input string nm, input int maxc);
        int n;
        n = 0;
        while (m_state != 1 && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) fail_timeout(nm);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, ".rsp_valid"}, 16'(rsp_valid), 16'h0);
        chk({nm, ".rsp_data"},  rsp_data, 16'h0);
        chk({nm, ".flags"},     16'(flags), 16'h0);
        chk({nm, ".busy"},      16'(busy), 16'h0);
        chk({nm, ".req_ready"}, 16'(req_ready), 16'h0);
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=%b expected=none at %0t", rsp_valid, $time);
                end else begin
                    e = sb[0];
                    chk("rsp_id",    16'(rsp_valid[e.id]), 16'h1);
                    chk("rsp_data",  rsp_data, e.data);
                    chk("rsp_flags", 16'(flags), 16'(e.fl));
                    if ((rsp_valid & rsp_ready) != 2'b00) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ADD: 0x8000 + 0x7FFF.
        issue(0, 4'd0, 16'h8000, 16'h7FFF);
        refill();
        wait_idle("add", 20);
        chk("add_flags", 16'(flags), 16'(3'b100));

        // SUB to zero, then requester 1 must leave flags alone.
        issue(0, 4'd1, 16'h0005, 16'h0005);
        refill();
        wait_idle("sub", 20);
        chk("sub_flags", 16'(flags), 16'(3'b010));
        issue(1, 4'd0, 16'h0001, 16'h0001);
        refill();
        wait_idle("req1_add", 20);
        chk("req1_flags", 16'(flags), 16'(3'b010));

        // Contention: both continuously valid, grants must alternate.
        issue(0, 4'd2, 16'hA5A5, 16'h5A5A);
        issue(0, 4'd3, 16'h1234, 16'h0000);
        issue(1, 4'd4, 16'h0001, 16'h0002);
        issue(1, 4'd7, 16'h7F80, 16'h0180);
        refill();
        wait_idle("contention", 40);

        // Backpressure: only the non-issuing ready bit set.
        rsp_ready = 2'b10;
        issue(0, 4'd0, 16'h1234, 16'h1111);
        refill();
        repeat (8) step();
        rsp_ready = 2'b01;
        wait_idle("backpressure", 20);
        rsp_ready = 2'b11;

        // Flag masking: set N and V, then ROR may only touch Z.
        issue(0, 4'd0, 16'h7FFF, 16'h0001);
        issue(0, 4'd6, 16'h0001, 16'h0002);
        refill();
        wait_idle("ror", 30);
        chk("ror_flags", 16'(flags), 16'(3'b101));

        // Reset during EXEC.
        issue(0, 4'd5, 16'h0008, 16'h0001);
        refill();
        wait_accept("sra_accept", 10);
        rst = 1'b1;
        #1;
        check_reset_outputs("midop");
        sb.delete();
        m_state = 0;
        m_rr    = 1'b0;
        m_flags = 3'b000;
        acc     = 2'b00;
        @(negedge clk);
        check_reset_outputs("midop_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1, 4'd0, 16'h0002, 16'h0003);
        issue(0, 4'd2, 16'h00FF, 16'h0F0F);
        refill();
        wait_idle("post_reset", 30);

        // Randomized traffic with backpressure and withdrawn requests.
        rr_rand = 1;
        drop_en = 1;
        for (int c = 0; c < 3000; c++) begin
            if (sq0.size() == 0 && $urandom_range(0, 2) == 0)
                issue(0, 4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom));
            if (sq1.size() == 0 && $urandom_range(0, 2) == 0)
                issue(1, 4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom));
            step();
        end
        rr_rand = 0;
        drop_en = 0;
        rsp_ready = 2'b11;
        wait_idle("drain", 60);
        step();
        chk("sb_empty", 16'(sb.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
